usb_dfifo_arbiter: RTL
======================

# usb_dfifo_arbiter

Shares the USB OTG controller's single-port 2048 x 35 data-FIFO SRAM between the controller's DFIFO port and a secondary maintenance port used for FIFO inspection, scrubbing and preload. The controller's DFIFO port cannot be stalled, so it always has absolute priority and passes to the RAM with no added latency. Maintenance accesses are slotted into idle RAM cycles through a valid/ready handshake. The block sits in the USB wrapper between the OTG core and the SRAM, and absorbs the core's active-low strobes.

## Interface
- ADDR_W, 11, RAM address width.
- DATA_W, 35, RAM word width.
- STARVE_LIMIT, 255, number of blocked maintenance cycles after which `dbg_starved` is raised; counter width is $clog2(STARVE_LIMIT+1).

Ports:
- aclk  in  1  clock; the RAM and the OTG core's hclk use this same clock.
- areset  in  1  reset, asynchronous, active-high.
- core_ce_n  in  1  core chip enable, active low.
- core_we_n  in  1  core write enable, active low; ignored when core_ce_n=1.
- core_addr  in  ADDR_W  core address.
- core_wdata  in  DATA_W  core write data.
- core_rdata  out  DATA_W  read data to core; equals ram_dout.
- dbg_req_valid  in  1  maintenance request valid.
- dbg_req_ready  out  1  maintenance request accepted this cycle.
- dbg_req_we  in  1  1=write, 0=read.
- dbg_req_addr  in  ADDR_W  maintenance address.
- dbg_req_wdata  in  DATA_W  maintenance write data.
- dbg_rsp_valid  out  1  response available.
- dbg_rsp_ready  in  1  response consumed.
- dbg_rsp_rdata  out  DATA_W  read data; 0 for write acks.
- dbg_starved  out  1  maintenance request blocked for ≥ STARVE_LIMIT cycles.
- ram_en  out  1  RAM enable, active high.
- ram_we  out  1  RAM write enable, active high.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_dout  in  DATA_W  RAM read data; read latency is 1.

## Operation
- Core access is `core_act = ~core_ce_n`.
- RAM mux:
  - If core_act: ram_en=1, ram_we=~core_we_n, and address/data come from the core, combinationally.
  - Else if a maintenance request is granted: ram_en=1, ram_we=dbg_req_we, and address/data come from dbg_req_*.
  - Otherwise ram_en=0, ram_we=0.
- core_rdata = ram_dout, unconditionally. The core only samples it the cycle after its own read.
- FSM states: IDLE, RD_WAIT, RSP.
  - dbg_req_ready = (state==IDLE) & ~core_act & ~areset.
  - Grant happens when dbg_req_valid & dbg_req_ready.
  - Read grant: go to RD_WAIT. In RD_WAIT, capture ram_dout into the dbg_rsp_rdata register, then go to RSP.
  - Write grant: set dbg_rsp_rdata=0 and go directly to RSP.
  - RSP: dbg_rsp_valid=1. On dbg_rsp_ready, go to IDLE.
- Core accesses are allowed in RD_WAIT and RSP. They do not corrupt the capture, because ram_dout in RD_WAIT reflects the granted read.
- Only one maintenance transaction is outstanding at a time.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, each cycle that state==IDLE, dbg_req_valid=1 and core_act=1.
  - Clears on grant.
  - dbg_starved = (count == STARVE_LIMIT).
  - It is not cleared by dbg_req_valid dropping; only a grant or reset clears it.
- Reset is asynchronous, and mid-operation reset drops any pending response:
  - State returns to IDLE.
  - Counter, dbg_rsp_valid and dbg_rsp_rdata clear to 0.
  - ram_en and ram_we are forced to 0 while areset=1, even if core_act=1.

## Timing
- Reset values: dbg_req_ready=0, dbg_rsp_valid=0, dbg_rsp_rdata=0, dbg_starved=0, ram_en=0, ram_we=0.
- Core path adds zero cycles: core read at T gives core_rdata at T+1.
- Maintenance read granted at T:
  - RAM access at T.
  - Capture at the end of T+1.
  - dbg_rsp_valid=1 from T+2.
- Maintenance write granted at T: RAM write at T, dbg_rsp_valid=1 from T+1.
- If dbg_rsp_ready=1 in the first RSP cycle, the next grant is possible in the following cycle.
- dbg_req_ready is combinational from core_ce_n. The requester must hold dbg_req_* stable until the grant.

## Test plan
- **Idle maintenance write then read:**
  - Write addr 0x123 data 0x5_A5A5_A5A5, with rsp_ready tied 1.
  - Then read 0x123.
  - Expect rsp_valid one cycle after the write grant with rdata=0, then two cycles after the read grant with rdata=0x5_A5A5_A5A5.
- **Core priority:**
  - Hold core_ce_n=0 for 10 cycles while dbg_req_valid=1.
  - Expect dbg_req_ready=0 throughout, ram_addr=core_addr each cycle, and a grant on the first cycle core_ce_n=1.
- **Core read during RD_WAIT:**
  - Maintenance read of 0x010 (holding 0x1), then a core read of 0x020 (holding 0x2) in the next cycle.
  - Expect dbg_rsp_rdata=0x1 and core_rdata=0x2 the cycle after the core read.
- **Response backpressure:**
  - Keep rsp_ready=0 for 5 cycles.
  - Expect rsp_valid and rdata held, and dbg_req_ready=0, until the handshake.
- **Starvation, with STARVE_LIMIT=4:**
  - Keep the core busy for 6 cycles with a maintenance request pending.
  - Expect dbg_starved=1 from the 5th cycle, and cleared the cycle after the grant.
- **Reset mid-read:**
  - Assert areset in RD_WAIT.
  - Expect immediate rsp_valid=0, ram_en=0 and dbg_req_ready=0.
  - After release, expect IDLE and no spurious response.

Source files
------------

// File: rtl/usb_dfifo_arbiter.sv
// Arbitrates the OTG data-FIFO SRAM between the core's DFIFO port, which is never stalled,
// and a valid/ready maintenance port that is slotted into idle RAM cycles.
module usb_dfifo_arbiter #(
    parameter int unsigned ADDR_W       = 11,
    parameter int unsigned DATA_W       = 35,
    parameter int unsigned STARVE_LIMIT = 255
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              core_ce_n,
    input  logic              core_we_n,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              dbg_req_valid,
    output logic              dbg_req_ready,
    input  logic              dbg_req_we,
    input  logic [ADDR_W-1:0] dbg_req_addr,
    input  logic [DATA_W-1:0] dbg_req_wdata,
    output logic              dbg_rsp_valid,
    input  logic              dbg_rsp_ready,
    output logic [DATA_W-1:0] dbg_rsp_rdata,
    output logic              dbg_starved,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StRdWait, StRsp} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] starve_q;
    logic             core_act;
    logic             grant;

    assign core_act      = ~core_ce_n;
    assign dbg_req_ready = (state_q == StIdle) & ~core_act & ~areset;
    assign grant         = dbg_req_valid & dbg_req_ready;
    assign core_rdata    = ram_dout;
    assign dbg_starved   = (starve_q == STARVE_MAX);

    // The core path is purely combinational so the core sees no added latency.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = core_addr;
        ram_din  = core_wdata;
        if (areset) begin
            ram_en = 1'b0;
        end else if (core_act) begin
            ram_en = 1'b1;
            ram_we = ~core_we_n;
        end else if (grant) begin
            ram_en   = 1'b1;
            ram_we   = dbg_req_we;
            ram_addr = dbg_req_addr;
            ram_din  = dbg_req_wdata;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q       <= StIdle;
            dbg_rsp_valid <= 1'b0;
            dbg_rsp_rdata <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant) begin
                        if (dbg_req_we) begin
                            dbg_rsp_rdata <= '0;
                            dbg_rsp_valid <= 1'b1;
                            state_q       <= StRsp;
                        end else begin
                            state_q <= StRdWait;
                        end
                    end
                end
                StRdWait: begin
                    // ram_dout still belongs to the granted read, whatever the core does now.
                    dbg_rsp_rdata <= ram_dout;
                    dbg_rsp_valid <= 1'b1;
                    state_q       <= StRsp;
                end
                StRsp: begin
                    if (dbg_rsp_ready) begin
                        dbg_rsp_valid <= 1'b0;
                        state_q       <= StIdle;
                    end
                end
                default: begin
                    dbg_rsp_valid <= 1'b0;
                    state_q       <= StIdle;
                end
            endcase
        end
    end

    // Only a grant clears the count; a requester withdrawing does not.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            starve_q <= '0;
        end else if (grant) begin
            starve_q <= '0;
        end else if ((state_q == StIdle) && dbg_req_valid && core_act &&
                     (starve_q != STARVE_MAX)) begin
            starve_q <= starve_q + CNT_W'(1);
        end
    end

endmodule
